// File: rtl/fp_normalize_pipe_if.sv
// Handshake and data bundle for the FP normalise/round pipeline.
// The upstream side (in_*) carries the aligned significand, carry and GRS bits;
// the downstream side (out_*) carries the packed-ready result and flags.
// The DUT connects through the slave modport, the driver through master.
`timescale 1ns/1ps
interface fp_normalize_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) ();
  logic             in_valid;
  logic             in_ready;
  logic             in_sign;
  logic [EXP_W-1:0] in_exp;
  logic [MAN_W:0]   in_mant;
  logic             in_carry;
  logic             in_guard;
  logic             in_round;
  logic             in_sticky;

  logic             out_valid;
  logic             out_ready;
  logic             out_sign;
  logic [EXP_W-1:0] out_exp;
  logic [MAN_W-1:0] out_mant;
  logic             out_overflow;
  logic             out_underflow;
  logic             out_inexact;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, in_carry, in_guard, in_round, in_sticky,
    output out_ready,
    input  in_ready,
    input  out_valid, out_sign, out_exp, out_mant, out_overflow, out_underflow, out_inexact
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, in_carry, in_guard, in_round, in_sticky,
    input  out_ready,
    output in_ready,
    output out_valid, out_sign, out_exp, out_mant, out_overflow, out_underflow, out_inexact
  );
endinterface

// File: rtl/fp_normalize_pipe.sv
// Two-stage normalise-and-round stage for the FP adder datapath.
//   Stage 1: normalise by right shift on carry-out or left shift by the
//            leading-zero count; classify zero and tiny results.
//   Stage 2: round-to-nearest-even, overflow/underflow detection, flags.
// Valid/ready on both sides; in_ready is combinational from out_ready.
// Optional macro FPNORM_SUBNORMAL_EN: gradual underflow (subnormal results)
// instead of the default flush-to-zero.
`timescale 1ns/1ps
module fp_normalize_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic              clk,
  input  logic              reset_n,
  fp_normalize_pipe_if.slave bus
);

  // Exponent arithmetic is done signed with two spare bits so that both the
  // carry increment and the LZC decrement fit without wrapping.
  localparam int             XW      = EXP_W + 2;
  localparam int             LZ_W    = $clog2(MAN_W + 2);
  localparam logic [XW-1:0]  EXP_MAX = XW'((1 << EXP_W) - 1);

  // Stage-1 payload: normalised fraction (implicit bit dropped) plus GRS.
  typedef struct packed {
    logic             sign;
    logic             zero;
    logic             tiny;
    logic [XW-1:0]    exp;
    logic [MAN_W-1:0] frac;
    logic             g;
    logic             r;
    logic             s;
  } norm_t;

  // Stage-2 payload: the final result as presented on the output port.
  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] mant;
    logic             ovf;
    logic             unf;
    logic             inx;
  } res_t;

  logic  s1_valid_q, s1_valid_d;
  logic  s2_valid_q, s2_valid_d;
  norm_t s1_q, s1_d, norm;
  res_t  s2_q, s2_d, rnd;
  logic  s1_adv, s2_adv;

  // A stage moves forward when it is empty or its successor is moving.
  assign s2_adv      = !s2_valid_q || bus.out_ready;
  assign s1_adv      = !s1_valid_q || s2_adv;
  assign bus.in_ready = s1_adv;

  logic [LZ_W-1:0] lz;

  // Leading-zero count of the incoming significand (highest set bit wins).
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    lz = '0;
    for (int i = 0; i <= MAN_W; i++) begin
      if (bus.in_mant[i]) lz = LZ_W'(MAN_W - i);
    end
  end

  logic [XW-1:0]        lz_x, exp_in_x, shamt;
  logic signed [XW-1:0] exp_lz;
  logic [MAN_W+1:0]     ext_sh;

  // Stage-1 normalisation: carry right-shift, LZC left-shift or zero beat.
  always_comb begin
    norm      = '0;
    lz_x      = XW'(lz);
    exp_in_x  = XW'(bus.in_exp);
    exp_lz    = $signed(exp_in_x) - $signed(lz_x);
    shamt     = lz_x;
    ext_sh    = '0;
    norm.sign = bus.in_sign;
    if (!bus.in_carry && (bus.in_mant == '0)) begin
      norm.zero = 1'b1;
    end else if (bus.in_carry) begin
      // {1, mant} >> 1: the new implicit bit is the carry, mant[0] becomes G.
      norm.frac = bus.in_mant[MAN_W:1];
      norm.g    = bus.in_mant[0];
      norm.r    = bus.in_guard;
      norm.s    = bus.in_round | bus.in_sticky;
      norm.exp  = exp_in_x + XW'(1);
    end else begin
      norm.tiny = exp_lz[XW-1] || (exp_lz == '0);
`ifdef FPNORM_SUBNORMAL_EN
      // Stop the shift where the exponent reaches the subnormal boundary.
      if (norm.tiny) shamt = (exp_in_x == '0) ? '0 : exp_in_x - XW'(1);
`endif
      // The implicit bit is dropped before the shift: when shamt > 0 it is
      // zero anyway, and when shamt = 0 it is exactly the bit being discarded.
      ext_sh    = {bus.in_mant[MAN_W-1:0], bus.in_guard, bus.in_round} << shamt;
      norm.frac = ext_sh[MAN_W+1:2];
      norm.g    = ext_sh[1];
      norm.r    = ext_sh[0];
      norm.s    = bus.in_sticky;
      norm.exp  = norm.tiny ? '0 : exp_lz;
    end
  end

  logic             inc;
  logic [MAN_W:0]   sum;
  logic [XW-1:0]    exp_f;

  // Stage-2 RNE rounding, overflow saturation and underflow handling.
  always_comb begin
    rnd      = '0;
    inc      = s1_q.g & (s1_q.r | s1_q.s | s1_q.frac[0]);
    sum      = {1'b0, s1_q.frac} + (MAN_W+1)'(inc);
    // A fraction carry means the significand became 10.000..: bump exponent.
    exp_f    = s1_q.exp + XW'(sum[MAN_W]);
    rnd.sign = s1_q.sign;
    if (s1_q.zero) begin
      rnd.sign = s1_q.sign;
    end else if (s1_q.tiny) begin
`ifdef FPNORM_SUBNORMAL_EN
      // A carry into the implicit position promotes the subnormal to exp=1.
      rnd.exp  = EXP_W'(sum[MAN_W]);
      rnd.mant = sum[MAN_W-1:0];
      rnd.inx  = s1_q.g | s1_q.r | s1_q.s;
      rnd.unf  = s1_q.g | s1_q.r | s1_q.s;
`else
      rnd.unf  = 1'b1;
      rnd.inx  = 1'b1;
`endif
    end else if (exp_f >= EXP_MAX) begin
      rnd.exp = '1;
      rnd.ovf = 1'b1;
      rnd.inx = 1'b1;
    end else begin
      rnd.exp  = exp_f[EXP_W-1:0];
      rnd.mant = sum[MAN_W-1:0];
      rnd.inx  = s1_q.g | s1_q.r | s1_q.s;
    end
  end

  // Next-state for both pipeline stages; bubbles load all-zero payloads so
  // the output flags read 0 whenever out_valid is low.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    s2_valid_d = s2_valid_q;
    s2_d       = s2_q;
    if (s1_adv) begin
      s1_valid_d = bus.in_valid;
      s1_d       = bus.in_valid ? norm : '0;
    end
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      s2_d       = s1_valid_q ? rnd : '0;
    end
  end

  // Pipeline registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: data registers are cleared too, so a reset mid-stall leaves no stale result on the port.
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
    end
  end

  assign bus.out_valid     = s2_valid_q;
  assign bus.out_sign      = s2_q.sign;
  assign bus.out_exp       = s2_q.exp;
  assign bus.out_mant      = s2_q.mant;
  assign bus.out_overflow  = s2_q.ovf;
  assign bus.out_underflow = s2_q.unf;
  assign bus.out_inexact   = s2_q.inx;

endmodule

// File: tb/tb_fp_normalize_pipe.sv
// Bench for fp_normalize_pipe (EXP_W=8, MAN_W=23): a table of directed
// vectors streamed at full rate, then hand-written back-pressure and
// mid-stall reset sequences.
`timescale 1ns/1ps
module tb_fp_normalize_pipe;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fp_normalize_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

  fp_normalize_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    string       name;
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] mant;
    logic        carry;
    logic [2:0]  grs;
    logic [7:0]  e_exp;
    logic [22:0] e_mant;
    logic [2:0]  e_flags; // {overflow, underflow, inexact}
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   idx, acc, rcv;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic void add_vec(input string n, input logic sg, input logic [7:0] e,
                                  input logic [23:0] m, input logic c, input logic [2:0] grs,
                                  input logic [7:0] ee, input logic [22:0] em, input logic [2:0] fl);
    vec_t v;
    v.name = n; v.sign = sg; v.exp = e; v.mant = m; v.carry = c; v.grs = grs;
    v.e_exp = ee; v.e_mant = em; v.e_flags = fl;
    vecs.push_back(v);
  endfunction

  // {valid, sign, exp, mant, ovf, unf, inx}
  function automatic logic [63:0] out_word();
    return 64'({bus.out_valid, bus.out_sign, bus.out_exp, bus.out_mant,
                bus.out_overflow, bus.out_underflow, bus.out_inexact});
  endfunction

  function automatic logic [63:0] exp_word(input vec_t v);
    return 64'({1'b1, v.sign, v.e_exp, v.e_mant, v.e_flags});
  endfunction

  task automatic drive_vec(input vec_t v);
    bus.in_valid  = 1'b1;
    bus.in_sign   = v.sign;
    bus.in_exp    = v.exp;
    bus.in_mant   = v.mant;
    bus.in_carry  = v.carry;
    bus.in_guard  = v.grs[2];
    bus.in_round  = v.grs[1];
    bus.in_sticky = v.grs[0];
  endtask

  task automatic drive_idle();
    bus.in_valid  = 1'b0;
    bus.in_sign   = 1'b0;
    bus.in_exp    = '0;
    bus.in_mant   = '0;
    bus.in_carry  = 1'b0;
    bus.in_guard  = 1'b0;
    bus.in_round  = 1'b0;
    bus.in_sticky = 1'b0;
  endtask

  // Stream beat k: a plain normalised value tagged by its exponent.
  task automatic drive_beat(input int k);
    drive_idle();
    bus.in_valid = 1'b1;
    bus.in_exp   = 8'(8'h10 + k);
    bus.in_mant  = 24'h800000;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    bus.out_ready = 1'b1;

    add_vec("pass_through", 0, 8'h7F, 24'h800000, 0, 3'b000, 8'h7F, 23'h000000, 3'b000);
    add_vec("carry_rnd_carry", 0, 8'h80, 24'hFFFFFF, 1, 3'b000, 8'h82, 23'h000000, 3'b001);
    add_vec("deep_lzc", 0, 8'h7F, 24'h000001, 0, 3'b000, 8'h68, 23'h000000, 3'b000);
    add_vec("rne_tie_odd", 0, 8'h7F, 24'h800001, 0, 3'b100, 8'h7F, 23'h000002, 3'b001);
    add_vec("rne_tie_even", 0, 8'h7F, 24'h800000, 0, 3'b100, 8'h7F, 23'h000000, 3'b001);
    add_vec("rnd_above_half", 0, 8'h7F, 24'h800000, 0, 3'b110, 8'h7F, 23'h000001, 3'b001);
    add_vec("rnd_below_half", 0, 8'h7F, 24'h800002, 0, 3'b011, 8'h7F, 23'h000002, 3'b001);
    add_vec("overflow_carry", 0, 8'hFE, 24'h800000, 1, 3'b000, 8'hFF, 23'h000000, 3'b101);
    add_vec("overflow_round", 0, 8'hFE, 24'hFFFFFF, 0, 3'b100, 8'hFF, 23'h000000, 3'b101);
    add_vec("zero_beat", 1, 8'h55, 24'h000000, 0, 3'b111, 8'h00, 23'h000000, 3'b000);
    add_vec("carry_neg", 1, 8'h10, 24'h000000, 1, 3'b000, 8'h11, 23'h000000, 3'b000);
    add_vec("lzc1_guard_in", 0, 8'h7F, 24'h400000, 0, 3'b100, 8'h7E, 23'h000001, 3'b000);
`ifdef FPNORM_SUBNORMAL_EN
    add_vec("underflow", 0, 8'h05, 24'h000100, 0, 3'b000, 8'h00, 23'h001000, 3'b000);
    add_vec("subnorm_exact", 0, 8'h01, 24'h400000, 0, 3'b000, 8'h00, 23'h400000, 3'b000);
    add_vec("subnorm_promote", 1, 8'h01, 24'h7FFFFF, 0, 3'b110, 8'h01, 23'h000000, 3'b011);
`else
    add_vec("underflow", 0, 8'h05, 24'h000100, 0, 3'b000, 8'h00, 23'h000000, 3'b011);
    add_vec("subnorm_exact", 0, 8'h01, 24'h400000, 0, 3'b000, 8'h00, 23'h000000, 3'b011);
    add_vec("subnorm_promote", 1, 8'h01, 24'h7FFFFF, 0, 3'b110, 8'h00, 23'h000000, 3'b011);
`endif

    // Reset state
    #1;
    check("in_reset_out_valid", 64'(bus.out_valid), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("rst_rel_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_rel_in_ready", 64'(bus.in_ready), 64'd1);

    // Table vectors, one per cycle, results two cycles later
    for (int c = 0; c < vecs.size() + 2; c++) begin
      @(negedge clk);
      if (c >= 2) check(vecs[c-2].name, out_word(), exp_word(vecs[c-2]));
      if (c < vecs.size()) drive_vec(vecs[c]);
      else drive_idle();
    end

    // Back-pressure: continuous stream, out_ready low for 4 cycles
    idx = 0; acc = 0; rcv = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus.out_ready = 1'b0;
      drive_beat(idx);
      #1;
      if (bus.out_valid) check("stall_hold_exp", 64'(bus.out_exp), 64'h10);
      if (bus.in_ready) begin
        idx++;
        acc++;
      end
    end
    check("stall_accepted", 64'(acc), 64'd2);
    check("stall_in_ready", 64'(bus.in_ready), 64'd0);
    check("stall_out_valid", 64'(bus.out_valid), 64'd1);

    for (int c = 0; c < 20 && rcv < 6; c++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      if (idx < 6) drive_beat(idx);
      else drive_idle();
      #1;
      if (bus.out_valid) begin
        check("order_exp", 64'(bus.out_exp), 64'(8'h10 + rcv));
        rcv++;
      end
      if (bus.in_valid && bus.in_ready) idx++;
    end
    check("drained_count", 64'(rcv), 64'd6);

    // Reset pulsed mid-stall
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.out_ready = 1'b0;
      drive_beat(c);
    end
    @(negedge clk); #1;
    check("prestall_out_valid", 64'(bus.out_valid), 64'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check("midstall_rst_valid", 64'(bus.out_valid), 64'd0);
    check("midstall_rst_exp", 64'(bus.out_exp), 64'd0);
    drive_idle();
    @(negedge clk);
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Pipe still works after the reset
    @(negedge clk);
    drive_vec(vecs[3]);
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    check("post_rst_vector", out_word(), exp_word(vecs[3]));

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end
endmodule
